// File: rtl/memory_cycle.sv
// Memory stage of the five-stage RISC-V pipeline: word loads/stores against an
// internal data memory, writeback selection, and the M/W pipeline register.
module memory_cycle #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_M,
  input  logic        MemWrite_M,
  input  logic        ResultSrc_M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] AluResult_M,
  input  logic [31:0] WriteData_M,
  input  logic        Stall_M,
  input  logic        Flush_W,
  output logic        RegWrite_W,
  output logic [4:0]  RD_W,
  output logic [31:0] Result_W,
  output logic [31:0] AluResult_W,
  output logic        Misalign_W
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] word_index;
  logic          misalign;
  logic          mem_write_en;
  logic [31:0]   read_data;
  logic [31:0]   result;

  // Upper address bits are dropped, so byte addresses wrap modulo 4*DEPTH.
  assign word_index   = AluResult_M[AW+1:2];
  assign misalign     = (MemWrite_M | ResultSrc_M) & (AluResult_M[1:0] != 2'b00);
  assign read_data    = mem[word_index];
  assign mem_write_en = MemWrite_M & ~misalign & ~Stall_M & ~rst;

  always_comb begin
    result = AluResult_M;
    if (ResultSrc_M) begin
      result = misalign ? 32'd0 : read_data;
    end
  end

  // Contents survive reset; a flush still lets a same-cycle store complete.
  always_ff @(posedge clk) begin
    if (mem_write_en) begin
      mem[word_index] <= WriteData_M;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Flush_W) begin
      RegWrite_W  <= 1'b0;
      RD_W        <= 5'd0;
      Result_W    <= 32'd0;
      AluResult_W <= 32'd0;
      Misalign_W  <= 1'b0;
    end else if (!Stall_M) begin
      RegWrite_W  <= RegWrite_M & ~misalign;
      RD_W        <= RD_M;
      Result_W    <= result;
      AluResult_W <= AluResult_M;
      Misalign_W  <= misalign;
    end
  end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory stage of the five-stage RISC-V pipeline. Consumes the execute-to-memory register outputs (ALU result, store data, destination register and control bits), performs word loads and stores against an internal data memory, selects the writeback value, and registers everything into the memory-to-writeback (M/W) pipeline register that feeds the register file and the forwarding paths.

## Interface
- DEPTH, 1024: data memory size in 32-bit words; power of two.
- AW, 10: word-index width, log2(DEPTH).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- RegWrite_M  in  1  instruction writes the register file.
- MemWrite_M  in  1  instruction is a store (sw).
- ResultSrc_M  in  1  0 = ALU result, 1 = memory read data (lw).
- RD_M  in  5  destination register index.
- AluResult_M  in  32  effective address or ALU result.
- WriteData_M  in  32  store data.
- Stall_M  in  1  hold the M/W register; the M-stage instruction is re-presented next cycle.
- Flush_W  in  1  insert a bubble into the M/W register.
- RegWrite_W  out  1  registered write enable to the register file.
- RD_W  out  5  registered destination index.
- Result_W  out  32  registered writeback value.
- AluResult_W  out  32  registered ALU result, used by forwarding.
- Misalign_W  out  1  registered flag: the W-stage instruction was a load or store with AluResult[1:0] != 0.

## Operation
- Memory is an array of DEPTH x 32 bits. Word index = AluResult_M[AW+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Read is combinational: ReadData = mem[index].
- Write is synchronous at the clk edge when MemWrite_M=1, AluResult_M[1:0]=0, Stall_M=0 and rst=0.
- The misalign condition is: (MemWrite_M or ResultSrc_M) and AluResult_M[1:0] != 0.
  - A misaligned store is suppressed.
  - A misaligned load yields RegWrite_W=0 and Result_W=0.
  - In both cases Misalign_W=1 for that instruction.
- Writeback selection: Result = ResultSrc_M ? ReadData : AluResult_M.
- Illegal MemWrite_M=1 with ResultSrc_M=1: the store is performed, and Result_W receives the pre-write data.
- M/W register update priority is rst > Flush_W > Stall_M > normal load.
  - rst: all W outputs are 0.
  - Flush_W: all W outputs are 0; a store presented in the same cycle is still performed unless Stall_M=1.
  - Stall_M: all W outputs hold their values; no memory write occurs.
  - Normal: RegWrite_W = RegWrite_M & ~misalign; RD_W, AluResult_W, Result_W and Misalign_W load from the M-stage values.
- RD_M=0: passed through unchanged; the register file ignores x0.
- Memory contents are not cleared by rst. A store coincident with rst is suppressed.

## Timing
- Reset values: RegWrite_W=0, RD_W=0, Result_W=0, AluResult_W=0, Misalign_W=0.
- Latency: M-stage inputs at cycle n appear on the W outputs after edge n+1.
- Store-to-load:
  - A store at cycle n is visible to a load presented at cycle n+1.
  - A load and a store cannot coexist in the stage, so a same-cycle read returns the old data.
- During a multi-cycle Stall_M, the W outputs stay constant and memory is unchanged. On release, the held M instruction completes exactly once.
- If rst is asserted mid-stall, the W outputs clear at the next edge, and the stall state carries no residue after rst is released.

## Test plan
- Reset: hold rst 2 cycles with random inputs. All W outputs are 0, and a store presented during rst leaves mem unchanged (checked by a later lw).
- Store/load: sw 0xDEADBEEF at addr 0x10, then lw addr 0x10 the next cycle. Result_W=0xDEADBEEF, RegWrite_W=1, and RD_W matches.
- ALU path: ResultSrc_M=0, AluResult_M=0x1234, RD_M=5, RegWrite_M=1. One cycle later Result_W=0x1234 and AluResult_W=0x1234.
- Misalign: sw 0x1111 at addr 0x13, then lw 0x10 and lw 0x13.
  - lw 0x10 returns the prior contents.
  - lw 0x13 gives Misalign_W=1, RegWrite_W=0, Result_W=0.
- Wrap: sw 0xA5A5A5A5 at byte addr 4*DEPTH+8, then lw addr 8. Result_W=0xA5A5A5A5.
- Stall/flush:
  - Stall_M 3 cycles with a pending sw: W outputs are frozen, and exactly one write occurs after release.
  - Flush_W with a pending lw: W outputs are 0 next cycle.
  - Flush_W and Stall_M together: W outputs are 0 and no write occurs.
